regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Sequences the shared single write port of the integer register file (32 x 32-bit, x0 hardwired zero by the write guard).
- After reset, zero-sweeps registers x1..x31 so no architectural register powers up as X.
- Then arbitrates NUM_REQ writeback sources (ALU, load unit, CSR/misc) onto the port round-robin, one write per cycle.
- Sits between the writeback stage and the register file; drives its wEn / write_sel / write_data inputs directly.

Parameters:
- REG_DATA_WIDTH, 32, register data width.
- REG_SEL_BITS, 5, register index width; file depth = 2^REG_SEL_BITS.
- NUM_REQ, 3, number of writeback requesters (>=2).

Ports:
- clock  in  1  sole clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NUM_REQ  per-requester write request.
- req_sel  in  NUM_REQ*REG_SEL_BITS  packed destination indices; requester i at [i*REG_SEL_BITS +: REG_SEL_BITS].
- req_data  in  NUM_REQ*REG_DATA_WIDTH  packed write data; same packing.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready.
- wEn  out  1  register file write enable (registered).
- write_sel  out  REG_SEL_BITS  register file write index (registered).
- write_data  out  REG_DATA_WIDTH  register file write data (registered).
- grant_id  out  $clog2(NUM_REQ)  index of the requester whose write is on the port this cycle.
- init_done  out  1  high once the zero-sweep completes.

Behaviour:
- Reset values: wEn=0, write_sel=0, write_data=0, grant_id=0, init_done=0, req_ready=0, rr_ptr=0, FSM=INIT, sweep_cnt=1.
- FSM state INIT:
  - Each cycle drives wEn=1, write_sel=sweep_cnt, write_data=0, then increments sweep_cnt.
  - At sweep_cnt = 2^REG_SEL_BITS-1 the transition goes to RUN. The sweep lasts exactly 31 cycles at default, covering x1..x31.
  - req_ready is held at all zeros during INIT.
- FSM state RUN:
  - init_done=1 from the first RUN cycle onward.
  - Combinational grant: the first requester i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready is one-hot on that i; all zeros if no valid.
  - On a transfer, the next edge registers write_sel=req_sel[i], write_data=req_data[i], grant_id=i, and wEn=1 unless req_sel[i]==0.
  - A write to x0 is accepted (ready asserted, handshake completes) but wEn stays 0.
  - rr_ptr <= (i+1) mod NUM_REQ after each transfer; rr_ptr is unchanged on idle cycles.
  - Idle cycle: wEn=0; write_sel, write_data and grant_id hold their previous values.
- Latency: handshake in cycle N produces the write on the port in cycle N+1, and the register file commits it at the edge ending cycle N+1. Throughput is 1 write per cycle.
- Requester rules:
  - Requesters hold valid, sel and data stable until ready.
  - Requesters may not retract valid without a transfer.
  - req_ready depends on req_valid; there is no combinational path from ready back to valid.
- Simultaneous valids: exactly one grant per cycle; losers wait. A persistent requester waits at most NUM_REQ-1 cycles.
- Reset asserted mid-sweep or mid-RUN: all outputs clear immediately (asynchronous), the FSM returns to INIT, and the sweep restarts from x1. Any in-flight accepted write is dropped.
- No RUN -> INIT transition other than reset.

Optional Feature:
- Macro: RF_ARB_STALL_CNT_EN.
- Defined: adds output stall_count (32 bits, reset 0).
  - In RUN, increments each cycle in which at least one req_valid is high and that requester is not granted.
  - Saturates at 0xFFFFFFFF.
  - Not counted during INIT.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package riscv_rf_pkg holds:
  - FSM state encoding RF_ARB_INIT=1'b0, RF_ARB_RUN=1'b1.
  - REG_ZERO index constant 0.
  - Default width constants.
- Natural sub-module: rr_grant, a combinational round-robin priority picker (req vector, rr_ptr -> one-hot grant, index, any_grant). It is reusable by the memory-port arbiter.

Test Plan:
- Reset release: observe 31 cycles of wEn=1, write_sel=1..31, write_data=0 with req_ready=0; init_done rises on cycle 32; a regFile model reads all registers as 0.
- RUN, single requester 1: valid, sel=5, data=0xDEADBEEF -> ready[1] that cycle; next cycle wEn=1, write_sel=5, write_data=0xDEADBEEF, grant_id=1.
- All three valid continuously with distinct sel/data, rr_ptr=0: grants 0,1,2,0,... one per cycle; each write appears one cycle after its handshake; no requester waits more than 2 cycles.
- Requester 2 writes sel=0, data=0x1234 -> ready[2]=1, next cycle wEn=0; x0 still reads 0; rr_ptr advances to 0.
- Assert reset at sweep cycle 10, release -> outputs 0 immediately while low; sweep restarts at write_sel=1; init_done low until 31 sweep cycles complete.
- With RF_ARB_STALL_CNT_EN defined, 3 requesters valid for 4 RUN cycles -> stall_count=4; with it undefined, the build has no stall_count port.

Source files
------------

// File: rtl/riscv_rf_pkg.sv
// rtl/riscv_rf_pkg.sv - shared register-file arbiter types and default widths
package riscv_rf_pkg;

  typedef enum logic {
    RF_ARB_INIT = 1'b0,
    RF_ARB_RUN  = 1'b1
  } rf_arb_state_t;

  localparam int REG_ZERO           = 0;
  localparam int DEF_REG_DATA_WIDTH = 32;
  localparam int DEF_REG_SEL_BITS   = 5;
  localparam int DEF_NUM_REQ        = 3;

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational round-robin picker: first request at or after i_ptr
module rr_grant #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % N]) begin
        o_grant = N'(1) << ((int'(i_ptr) + k) % N);
        o_idx   = IW'((int'(i_ptr) + k) % N);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - zero-sweeps x1..x31, then round-robins writeback sources onto the RF write port
// Optional stall_count output enabled by defining RF_ARB_STALL_CNT_EN.
module regfile_wb_arbiter
  import riscv_rf_pkg::*;
#(
  parameter  int REG_DATA_WIDTH = DEF_REG_DATA_WIDTH,
  parameter  int REG_SEL_BITS   = DEF_REG_SEL_BITS,
  parameter  int NUM_REQ        = DEF_NUM_REQ,
  localparam int GW             = $clog2(NUM_REQ)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*REG_SEL_BITS-1:0]   req_sel,
  input  logic [NUM_REQ*REG_DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              wEn,
  output logic [REG_SEL_BITS-1:0]           write_sel,
  output logic [REG_DATA_WIDTH-1:0]         write_data,
  output logic [GW-1:0]                     grant_id,
  output logic                              init_done
`ifdef RF_ARB_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_count
`endif
);

  localparam logic [REG_SEL_BITS-1:0] SWEEP_LAST = {REG_SEL_BITS{1'b1}};

  rf_arb_state_t           r_state;
  logic [GW-1:0]           r_rr_ptr;
  logic [REG_SEL_BITS-1:0] r_sweep_cnt;

  logic [NUM_REQ-1:0]        w_grant;
  logic [GW-1:0]             w_idx;
  logic                      w_any;
  logic                      w_xfer;
  logic [REG_SEL_BITS-1:0]   w_sel_g;
  logic [REG_DATA_WIDTH-1:0] w_data_g;

  rr_grant #(.N(NUM_REQ)) u_rr_grant (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = (r_state == RF_ARB_RUN) ? w_grant : '0;
  assign w_xfer    = (r_state == RF_ARB_RUN) && w_any;
  assign w_sel_g   = req_sel[int'(w_idx)*REG_SEL_BITS +: REG_SEL_BITS];
  assign w_data_g  = req_data[int'(w_idx)*REG_DATA_WIDTH +: REG_DATA_WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= RF_ARB_INIT;
      r_rr_ptr    <= '0;
      r_sweep_cnt <= REG_SEL_BITS'(1);
      wEn         <= 1'b0;
      write_sel   <= '0;
      write_data  <= '0;
      grant_id    <= '0;
      init_done   <= 1'b0;
    end else begin
      case (r_state)
        RF_ARB_INIT: begin
          wEn         <= 1'b1;
          write_sel   <= r_sweep_cnt;
          write_data  <= '0;
          r_sweep_cnt <= r_sweep_cnt + 1'b1;
          if (r_sweep_cnt == SWEEP_LAST) begin
            r_state   <= RF_ARB_RUN;
            init_done <= 1'b1;
          end
        end
        default: begin
          if (w_xfer) begin
            // x0 writes complete the handshake but never reach the file.
            wEn        <= (w_sel_g != REG_SEL_BITS'(REG_ZERO));
            write_sel  <= w_sel_g;
            write_data <= w_data_g;
            grant_id   <= w_idx;
            r_rr_ptr   <= (w_idx == GW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
          end else begin
            wEn <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef RF_ARB_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if ((r_state == RF_ARB_RUN) && |(req_valid & ~w_grant) && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized bench with behavioural write-port model for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int SB = 5;
  localparam int NR = 3;
  localparam int GW = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*SB-1:0] req_sel;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             wEn;
  logic [SB-1:0]    write_sel;
  logic [DW-1:0]    write_data;
  logic [GW-1:0]    grant_id;
  logic             init_done;
`ifdef RF_ARB_STALL_CNT_EN
  logic [31:0]      stall_count;
`endif

  regfile_wb_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_sel    (req_sel),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wEn        (wEn),
    .write_sel  (write_sel),
    .write_data (write_data),
    .grant_id   (grant_id),
    .init_done  (init_done)
`ifdef RF_ARB_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Model of the port: what the registered outputs must be this cycle.
  bit          m_run;
  int          m_cnt;
  bit          m_wen;
  int          m_sel;
  logic [31:0] m_data;
  int          m_gid;
  int          m_rr;
  logic [31:0] m_stall;
  int          waits [NR];
  logic [NR-1:0] hs_vec;

  initial begin
    bit          n_run;
    int          n_cnt, n_sel, n_gid, n_rr, g;
    bit          n_wen;
    logic [31:0] n_data, n_stall;
    logic [NR-1:0] exp_ready;
    hs_vec = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        m_run = 0; m_cnt = 1; m_wen = 0; m_sel = 0; m_data = 0;
        m_gid = 0; m_rr = 0; m_stall = 0;
        for (int i = 0; i < NR; i++) waits[i] = 0;
        exp_ready = '0;
      end else begin
        g = -1;
        if (m_run) begin
          for (int k = 0; k < NR; k++)
            if (g < 0 && req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        end
        exp_ready = (g >= 0) ? NR'(1 << g) : '0;
      end
      chk("ready", 64'(req_ready), 64'(exp_ready));
      chk("wen", 64'(wEn), 64'(m_wen));
      chk("write_sel", 64'(write_sel), 64'(m_sel));
      chk("write_data", 64'(write_data), 64'(m_data));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("init_done", 64'(init_done), 64'(m_run));
`ifdef RF_ARB_STALL_CNT_EN
      chk("stall_count", 64'(stall_count), 64'(m_stall));
`endif
      n_run = m_run; n_cnt = m_cnt; n_wen = m_wen; n_sel = m_sel;
      n_data = m_data; n_gid = m_gid; n_rr = m_rr; n_stall = m_stall;
      if (reset) begin
        if (!m_run) begin
          n_wen = 1; n_sel = m_cnt; n_data = 0; n_cnt = m_cnt + 1;
          if (m_cnt == 31) n_run = 1;
        end else begin
          if (g >= 0) begin
            n_sel  = int'(req_sel[g*SB +: SB]);
            n_data = req_data[g*DW +: DW];
            n_gid  = g;
            n_wen  = (n_sel != 0);
            n_rr   = (g + 1) % NR;
          end else begin
            n_wen = 0;
          end
          if ((req_valid & ~exp_ready) != 0 && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
          for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) begin
              chk("max_wait", 64'(waits[i] <= NR - 1), 64'd1);
              waits[i] = 0;
            end else if (req_valid[i]) begin
              waits[i]++;
            end
          end
        end
      end
      hs_vec = req_valid & req_ready;
      @(posedge clock);
      if (reset) begin
        m_run = n_run; m_cnt = n_cnt; m_wen = n_wen; m_sel = n_sel;
        m_data = n_data; m_gid = n_gid; m_rr = n_rr; m_stall = n_stall;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string name, input int exp_len);
    int n = 0;
    while (!init_done && n < 40) begin
      tick();
      n++;
    end
    chk(name, 64'(n), 64'(exp_len));
  endtask

  task automatic set_req(input int i, input bit v, input logic [SB-1:0] s, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_sel[i*SB +: SB]  = s;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (hs_vec[i] || !req_valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, ($urandom_range(0, 7) == 0) ? SB'(0) : SB'($urandom_range(1, 31)), $urandom);
          else
            req_valid[i] = 1'b0;
        end
      end
      tick();
    end
  endtask

  initial begin
    req_valid = '0;
    req_sel   = '0;
    req_data  = '0;
    repeat (3) tick();
    chk("reset_outputs", {wEn, write_sel, write_data, grant_id, init_done, req_ready}, 64'd0);
    reset = 1'b1;
    tick();
    chk("sweep_first", {wEn, write_sel, write_data}, {1'b1, 5'd1, 32'd0});
    wait_done("sweep_len", 30);
    chk("sweep_last", {wEn, write_sel}, {1'b1, 5'd31});

    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1 chk("single_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    chk("single_write", {wEn, write_sel, write_data, grant_id}, {1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1});

    set_req(2, 1'b1, 5'd0, 32'h0000_1234);
    #1 chk("x0_ready", 64'(req_ready), 64'b100);
    tick();
    req_valid = '0;
    chk("x0_wen", {wEn, write_sel, write_data, grant_id}, {1'b0, 5'd0, 32'h1234, 2'd2});

    for (int i = 0; i < NR; i++) set_req(i, 1'b1, SB'(7 + i), 32'hA000_0000 + i);
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_ready", 64'(req_ready), 64'(1 << (c % 3)));
      if (c > 0) chk("rr_write", {wEn, write_sel}, {1'b1, 5'(7 + (c - 1) % 3)});
      tick();
    end
    req_valid = '0;
    tick();

    random_phase(500);

    req_valid = '0;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1 chk("async_clear", {wEn, write_sel, write_data, grant_id, init_done}, 64'd0);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, SB'(20 + i), 32'hB000_0000 + i);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk("resweep_first", {wEn, write_sel}, {1'b1, 5'd1});
    wait_done("resweep_len", 30);
`ifdef RF_ARB_STALL_CNT_EN
    chk("stall_start", 64'(stall_count), 64'd0);
    repeat (4) tick();
    chk("stall_four", 64'(stall_count), 64'd4);
`endif
    random_phase(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
